voice_scheduler: RTL and testbench

Parametrised polyphonic voice scheduler. It sits between the key-input stage and the tone generator. It captures the pressed-key vector, builds an ordered list of active notes with a scan FSM, and time-multiplexes one note code at a time to the tone generator. The scheduling mode is runtime-selectable: round-robin ascending, round-robin descending, lowest-note mono, or highest-note mono. Key count, voice-list depth and slot length are all generalised as parameters.

---
 rtl/organ_pkg.sv | 24 ++
 rtl/voice_scheduler_if.sv | 40 ++++
 rtl/voice_scheduler_slot_timer.sv | 38 +++
 rtl/voice_scheduler.sv | 151 +++++++++++++++
 tb/tb_voice_scheduler.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/organ_pkg.sv
// Shared encodings for the organ voice path: scheduling modes, scheduler FSM states
// and the note-code convention (0 = silent, key k plays code k+1).
package organ_pkg;

  typedef enum logic [1:0] {
    MODE_RR_UP     = 2'b00,
    MODE_RR_DOWN   = 2'b01,
    MODE_MONO_LOW  = 2'b10,
    MODE_MONO_HIGH = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_PLAY = 2'd2
  } state_e;

  localparam int unsigned NOTE_SILENT = 0;

  function automatic int unsigned key_to_note(input int unsigned k);
    return k + 1;
  endfunction

endpackage

// File: rtl/voice_scheduler_if.sv
// Key-input/tone-generator side bundle of the voice scheduler.
// master drives keys and mode; slave (the scheduler) returns the note stream.
interface voice_scheduler_if
  import organ_pkg::*;
#(
  parameter int unsigned N_KEYS     = 8,
  parameter int unsigned MAX_VOICES = 8
);
  localparam int unsigned IDX_W = $clog2(N_KEYS + 1);
  localparam int unsigned CNT_W = $clog2(MAX_VOICES + 1);

  logic [N_KEYS-1:0] keys;
  mode_e             mode;
  logic [IDX_W-1:0]  note;
  logic              note_valid;
  logic [CNT_W-1:0]  note_count;
  logic              slot_start;
  logic              dropped;

  modport master (
    output keys,
    output mode,
    input  note,
    input  note_valid,
    input  note_count,
    input  slot_start,
    input  dropped
  );

  modport slave (
    input  keys,
    input  mode,
    output note,
    output note_valid,
    output note_count,
    output slot_start,
    output dropped
  );

endinterface

// File: rtl/voice_scheduler_slot_timer.sv
// Slot counter for the voice scheduler: counts 0..SLOT_CYCLES-1 while enabled and
// pulses tc on the last cycle of each slot.
module slot_timer #(
  parameter int unsigned SLOT_CYCLES = 100000,
  localparam int unsigned SLOT_W     = $clog2(SLOT_CYCLES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  output logic [SLOT_W-1:0] slot_cnt,
  output logic              tc
);

  localparam logic [SLOT_W-1:0] LAST = SLOT_W'(SLOT_CYCLES - 1);

  logic [SLOT_W-1:0] cnt_d;

  assign tc = en && (slot_cnt == LAST);

  always_comb begin
    cnt_d = slot_cnt;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : slot_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
    end else begin
      slot_cnt <= cnt_d;
    end
  end

endmodule

// File: rtl/voice_scheduler.sv
// Polyphonic voice scheduler: snapshots the key vector, scans it into an ordered voice
// list and plays one note per slot in round-robin or mono-priority order.
module voice_scheduler
  import organ_pkg::*;
#(
  parameter int unsigned N_KEYS      = 8,
  parameter int unsigned MAX_VOICES  = 8,
  parameter int unsigned SLOT_CYCLES = 100000
) (
  input logic         clk,
  input logic         rst_n,
  voice_scheduler_if.slave bus
);

  localparam int unsigned IDX_W  = $clog2(N_KEYS + 1);
  localparam int unsigned CNT_W  = $clog2(MAX_VOICES + 1);
  localparam int unsigned SLOT_W = $clog2(SLOT_CYCLES);
  localparam int unsigned K_W    = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
  localparam int unsigned PTR_W  = (MAX_VOICES > 1) ? $clog2(MAX_VOICES) : 1;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_VOICES);
  localparam logic [K_W-1:0]   LAST_K  = K_W'(N_KEYS - 1);

  state_e            state_q, state_d;
  logic [N_KEYS-1:0] keys_s_q;
  logic [N_KEYS-1:0] snap_q, snap_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  voice_q [MAX_VOICES];
  logic [IDX_W-1:0]  voice_d [MAX_VOICES];
  logic              drop_q, drop_d;

  logic              changed;
  logic              key_hit;
  logic              has_room;
  logic [CNT_W-1:0]  count_fin;
  logic [PTR_W-1:0]  last_ptr;
  logic [PTR_W-1:0]  init_last;
  logic              scan_done;
  logic              playing;
  logic              slot_en;
  logic              slot_clr;
  logic              slot_tc;
  logic [SLOT_W-1:0] slot_cnt;

  assign changed   = (keys_s_q != snap_q);
  assign key_hit   = snap_q[k_q];
  assign has_room  = (count_q < MAX_CNT);
  // Count including the key scanned this cycle, so the initial pointer sees the final list.
  assign count_fin = count_q + CNT_W'(key_hit && has_room);
  assign last_ptr  = PTR_W'(count_q - 1'b1);
  assign init_last = PTR_W'(count_fin - 1'b1);
  assign playing   = (state_q == ST_PLAY);
  assign scan_done = (state_q == ST_SCAN) && !changed && (k_q == LAST_K);
  assign slot_en   = playing && !changed;
  assign slot_clr  = changed || scan_done;

  slot_timer #(
    .SLOT_CYCLES (SLOT_CYCLES)
  ) u_slot_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (slot_en),
    .clr      (slot_clr),
    .slot_cnt (slot_cnt),
    .tc       (slot_tc)
  );

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    k_d     = k_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    voice_d = voice_q;
    drop_d  = drop_q;

    // Any change of the synchronised keys aborts whatever is in progress.
    if (changed) begin
      snap_d  = keys_s_q;
      k_d     = '0;
      count_d = '0;
      drop_d  = 1'b0;
      state_d = (keys_s_q != '0) ? ST_SCAN : ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_SCAN: begin
          if (key_hit) begin
            if (has_room) begin
              voice_d[PTR_W'(count_q)] = IDX_W'(k_q) + 1'b1;
            end else begin
              drop_d = 1'b1;
            end
          end
          count_d = count_fin;
          if (k_q == LAST_K) begin
            state_d = ST_PLAY;
            ptr_d   = ((bus.mode == MODE_RR_DOWN) || (bus.mode == MODE_MONO_HIGH)) ?
                      init_last : '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        ST_PLAY: begin
          // Mode is only looked at on slot boundaries.
          if (slot_tc) begin
            case (bus.mode)
              MODE_RR_UP:     ptr_d = (ptr_q == last_ptr) ? '0 : ptr_q + 1'b1;
              MODE_RR_DOWN:   ptr_d = (ptr_q == '0) ? last_ptr : ptr_q - 1'b1;
              MODE_MONO_LOW:  ptr_d = '0;
              MODE_MONO_HIGH: ptr_d = last_ptr;
              default:        ptr_d = '0;
            endcase
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      keys_s_q <= '0;
      snap_q   <= '0;
      k_q      <= '0;
      count_q  <= '0;
      ptr_q    <= '0;
      voice_q  <= '{default: '0};
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      keys_s_q <= bus.keys;
      snap_q   <= snap_d;
      k_q      <= k_d;
      count_q  <= count_d;
      ptr_q    <= ptr_d;
      voice_q  <= voice_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.note       = playing ? voice_q[ptr_q] : IDX_W'(NOTE_SILENT);
  assign bus.note_valid = playing;
  assign bus.note_count = playing ? count_q : '0;
  assign bus.slot_start = playing && (slot_cnt == '0);
  assign bus.dropped    = playing && drop_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Bench for voice_scheduler: two instances (8 and 2 voices) driven in parallel, checked
// against vector tables, hand sequences and a per-cycle behavioural model.
module tb_voice_scheduler;
  import organ_pkg::*;

  localparam int unsigned NK   = 8;
  localparam int unsigned SLOT = 4;

  logic    clk   = 1'b0;
  logic    rst_n = 1'b1;
  logic [NK-1:0] keys = '0;
  mode_e   mode  = MODE_RR_UP;
  bit      started = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  voice_scheduler_if #(.N_KEYS(NK), .MAX_VOICES(8)) if_a ();
  voice_scheduler_if #(.N_KEYS(NK), .MAX_VOICES(2)) if_b ();

  assign if_a.keys = keys;
  assign if_a.mode = mode;
  assign if_b.keys = keys;
  assign if_b.mode = mode;

  voice_scheduler #(.N_KEYS(NK), .MAX_VOICES(8), .SLOT_CYCLES(SLOT)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a)
  );

  voice_scheduler #(.N_KEYS(NK), .MAX_VOICES(2), .SLOT_CYCLES(SLOT)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b)
  );

  always #5 clk = ~clk;

  function automatic int maxv(input int d);
    return (d == 0) ? 8 : 2;
  endfunction
  function automatic int o_note(input int d);
    return (d == 0) ? int'(if_a.note) : int'(if_b.note);
  endfunction
  function automatic int o_valid(input int d);
    return (d == 0) ? int'(if_a.note_valid) : int'(if_b.note_valid);
  endfunction
  function automatic int o_cnt(input int d);
    return (d == 0) ? int'(if_a.note_count) : int'(if_b.note_count);
  endfunction
  function automatic int o_ss(input int d);
    return (d == 0) ? int'(if_a.slot_start) : int'(if_b.slot_start);
  endfunction
  function automatic int o_drop(input int d);
    return (d == 0) ? int'(if_a.dropped) : int'(if_b.dropped);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: timing from the change/scan/slot rules, list from the snapshot bits.
  logic [NK-1:0] m_ks, m_snap;
  bit m_scan, m_play;
  int m_age, m_phase;
  int m_list [2][8];
  int m_size [2];
  int m_ptr  [2];
  bit m_drop [2];

  task automatic model_reset();
    m_ks = '0; m_snap = '0; m_scan = 0; m_play = 0; m_age = 0; m_phase = 0;
    for (int d = 0; d < 2; d++) begin
      m_size[d] = 0; m_ptr[d] = 0; m_drop[d] = 0;
    end
  endtask

  // Advances the model across the next rising edge, using inputs as they stand now.
  task automatic model_step();
    if (m_ks != m_snap) begin
      m_snap = m_ks; m_scan = (m_ks != 0); m_play = 0; m_age = 0;
    end else if (m_scan) begin
      m_age++;
      if (m_age == NK) begin
        m_scan = 0; m_play = 1; m_phase = 0;
        for (int d = 0; d < 2; d++) begin
          m_size[d] = 0;
          for (int k = 0; k < NK; k++) begin
            if (m_snap[k] && m_size[d] < maxv(d)) begin
              m_list[d][m_size[d]] = k + 1;
              m_size[d]++;
            end
          end
          m_drop[d] = ($countones(m_snap) > maxv(d));
          m_ptr[d]  = (mode == MODE_RR_DOWN || mode == MODE_MONO_HIGH) ? m_size[d] - 1 : 0;
        end
      end
    end else if (m_play) begin
      m_phase++;
      if (m_phase == SLOT) begin
        m_phase = 0;
        for (int d = 0; d < 2; d++) begin
          case (mode)
            MODE_RR_UP:     m_ptr[d] = (m_ptr[d] + 1) % m_size[d];
            MODE_RR_DOWN:   m_ptr[d] = (m_ptr[d] + m_size[d] - 1) % m_size[d];
            MODE_MONO_LOW:  m_ptr[d] = 0;
            default:        m_ptr[d] = m_size[d] - 1;
          endcase
        end
      end
    end
    m_ks = keys;
  endtask

  initial begin
    wait (started);
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("mdl%0d_note", d), o_note(d), m_play ? m_list[d][m_ptr[d]] : 0);
        chk($sformatf("mdl%0d_valid", d), o_valid(d), int'(m_play));
        chk($sformatf("mdl%0d_count", d), o_cnt(d), m_play ? m_size[d] : 0);
        chk($sformatf("mdl%0d_slot_start", d), o_ss(d), int'(m_play && m_phase == 0));
        chk($sformatf("mdl%0d_dropped", d), o_drop(d), int'(m_play && m_drop[d]));
      end
      if (rst_n) model_step();
    end
  end

  // Called right after inputs change (just past a rising edge): silent through the
  // rescan, then first PLAY cycle on the 11th falling edge.
  task automatic lat_chk(input string nm, input int na, input int ca, input int da,
                         input int nb, input int cb, input int db);
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      if (j >= 3 && j <= 10) begin
        chk({nm, "_a_wait_valid"}, o_valid(0), 0);
        chk({nm, "_b_wait_valid"}, o_valid(1), 0);
      end
    end
    chk({nm, "_a_valid"}, o_valid(0), 1);
    chk({nm, "_a_slot_start"}, o_ss(0), 1);
    chk({nm, "_a_note"}, o_note(0), na);
    chk({nm, "_a_count"}, o_cnt(0), ca);
    chk({nm, "_a_dropped"}, o_drop(0), da);
    chk({nm, "_b_valid"}, o_valid(1), 1);
    chk({nm, "_b_slot_start"}, o_ss(1), 1);
    chk({nm, "_b_note"}, o_note(1), nb);
    chk({nm, "_b_count"}, o_cnt(1), cb);
    chk({nm, "_b_dropped"}, o_drop(1), db);
  endtask

  task automatic chk_silent(input string nm);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s%0d_note", nm, d), o_note(d), 0);
      chk($sformatf("%s%0d_valid", nm, d), o_valid(d), 0);
      chk($sformatf("%s%0d_count", nm, d), o_cnt(d), 0);
      chk($sformatf("%s%0d_slot_start", nm, d), o_ss(d), 0);
      chk($sformatf("%s%0d_dropped", nm, d), o_drop(d), 0);
    end
  endtask

  typedef struct {
    logic [NK-1:0] keys;
    mode_e mode;
    int na, ca, da;
    int nb, cb, db;
  } vec_t;

  vec_t vecs [8];
  int   seq3 [15];

  initial begin
    vecs[0] = '{8'b0000_0101, MODE_RR_UP,     1, 2, 0, 1, 2, 0};
    vecs[1] = '{8'b0000_0101, MODE_RR_DOWN,   3, 2, 0, 3, 2, 0};
    vecs[2] = '{8'b1001_0010, MODE_MONO_HIGH, 8, 3, 0, 5, 2, 1};
    vecs[3] = '{8'b1001_0010, MODE_MONO_LOW,  2, 3, 0, 2, 2, 1};
    vecs[4] = '{8'b0000_1111, MODE_RR_UP,     1, 4, 0, 1, 2, 1};
    vecs[5] = '{8'b0000_1111, MODE_MONO_HIGH, 4, 4, 0, 2, 2, 1};
    vecs[6] = '{8'b1000_0000, MODE_RR_DOWN,   8, 1, 0, 8, 1, 0};
    vecs[7] = '{8'b1111_1111, MODE_RR_DOWN,   8, 8, 0, 2, 2, 1};
    seq3    = '{1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1, 3, 3, 3, 3};

    #2 rst_n = 1'b0;
    started = 1'b1;
    @(negedge clk);
    chk_silent("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 keys = '0;
      repeat (3) @(posedge clk);
      #1 keys = vecs[i].keys; mode = vecs[i].mode;
      lat_chk($sformatf("vec%0d", i), vecs[i].na, vecs[i].ca, vecs[i].da,
              vecs[i].nb, vecs[i].cb, vecs[i].db);
    end

    // Three voices round-robin; switch to RR_DOWN mid-slot, effect only at the boundary.
    @(posedge clk); #1 keys = '0;
    repeat (3) @(posedge clk);
    #1 keys = 8'b0000_0111; mode = MODE_RR_UP;
    lat_chk("rr3", 1, 3, 0, 1, 2, 1);
    for (int j = 12; j <= 26; j++) begin
      @(negedge clk);
      chk($sformatf("rr3_note_%0d", j), o_note(0), seq3[j-12]);
      chk($sformatf("rr3_slot_start_%0d", j), o_ss(0), int'((j - 11) % 4 == 0));
      if (j == 16) begin
        @(posedge clk); #1 mode = MODE_RR_DOWN;
      end
    end

    // Release mid-slot: valid stays two more samples, then silent with no stray pulse.
    @(posedge clk); #1 keys = '0;
    @(negedge clk); chk("rel_valid_1", o_valid(0), 1);
    @(negedge clk); chk("rel_valid_2", o_valid(0), 1);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk_silent($sformatf("rel%0d_", j));
    end

    // New vector while scanning (k=3), then a new vector mid-slot while playing.
    @(posedge clk); #1 keys = 8'b0000_0011; mode = MODE_MONO_LOW;
    repeat (4) @(posedge clk);
    #1 keys = 8'b0001_1000;
    lat_chk("scan_abort", 4, 2, 0, 4, 2, 0);
    repeat (2) @(posedge clk);
    #1 keys = 8'b1100_0000; mode = MODE_MONO_HIGH;
    lat_chk("play_abort", 8, 2, 0, 8, 2, 0);

    // Reset pulse during a scan with keys held, then resume as a fresh change.
    @(posedge clk); #1 keys = '0;
    repeat (3) @(posedge clk);
    #1 keys = 8'b0010_0000; mode = MODE_RR_UP;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_silent("rst_scan");
    @(posedge clk); #1 rst_n = 1'b1;
    lat_chk("rst_resume", 6, 1, 0, 6, 1, 0);

    // Random key/mode traffic against the model only.
    for (int it = 0; it < 250; it++) begin
      int r;
      @(posedge clk); #1;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        keys = '0;
      end else if (r < 4) begin
        mode = mode_e'($urandom_range(0, 3));
      end else begin
        keys = NK'($urandom & $urandom);
        mode = mode_e'($urandom_range(0, 3));
      end
      repeat ($urandom_range(0, 30)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
